// File: rtl/matrix_pkg.sv
// Shared constants for the matrix display path: geometry defaults, swap FSM encoding, frame counter width.
package matrix_pkg;
   localparam int ROWS_DEF = 8;
   localparam int COLS_DEF = 8;
   localparam int FC_W     = 4;

   localparam logic [0:0] ST_FILL    = 1'b0;
   localparam logic [0:0] ST_PENDING = 1'b1;
endpackage

// File: rtl/matrix_frame_buffer_if.sv
// Loader/scanner-facing bundle of the frame buffer; master = loader+scanner side, slave = buffer.
interface matrix_frame_buffer_if
   import matrix_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic            wr_valid;
   logic            wr_ready;
   logic [RW-1:0]   wr_row;
   logic [COLS-1:0] wr_data;
   logic            commit;
   logic            frame_sync;
   logic [RW-1:0]   rd_row;
   logic [COLS-1:0] rd_data;
   logic            swap_done;
   logic [FC_W-1:0] frame_count;

   modport master (
      output wr_valid, wr_row, wr_data, commit, frame_sync, rd_row,
      input  wr_ready, rd_data, swap_done, frame_count
   );

   modport slave (
      input  wr_valid, wr_row, wr_data, commit, frame_sync, rd_row,
      output wr_ready, rd_data, swap_done, frame_count
   );
endinterface

// File: rtl/matrix_bank.sv
// One ROWS x COLS bit register file: single write port, combinational read, async clear.
// Out-of-range read addresses return zero.
module matrix_bank #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [RW-1:0]   waddr,
   input  logic [COLS-1:0] wdata,
   input  logic [RW-1:0]   raddr,
   output logic [COLS-1:0] rdata
);
   logic [COLS-1:0] mem_q [ROWS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROWS; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      if (int'(raddr) < ROWS) rdata = mem_q[raddr];
   end
endmodule

// File: rtl/matrix_frame_buffer.sv
// Double-buffered LED matrix frame store: loader fills the back bank, swap happens on the scanner's frame_sync.
// Read latency 1 cycle; wr_ready drops from commit until the swap so the back bank is frozen.
module matrix_frame_buffer
   import matrix_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF
) (
   input logic                  clock50MHz,
   input logic                  reset,
   matrix_frame_buffer_if.slave bus
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [0:0]      state_q, state_d;
   logic            bank_sel_q, bank_sel_d;
   logic [COLS-1:0] rd_data_q, rd_data_d;
   logic            swap_done_q, swap_done_d;
   logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

   logic            wr_fire;
   logic            swap;
   logic [COLS-1:0] rd0, rd1;

   assign bus.wr_ready    = (state_q == ST_FILL);
   assign bus.rd_data     = rd_data_q;
   assign bus.swap_done   = swap_done_q;
   assign bus.frame_count = frame_cnt_q;

   assign wr_fire = bus.wr_valid && (state_q == ST_FILL) && (int'(bus.wr_row) < ROWS);
   assign swap    = (state_q == ST_PENDING) && bus.frame_sync;

   // bank_sel names the front bank; writes always target the other one
   matrix_bank #(.ROWS(ROWS), .COLS(COLS)) u_bank0 (
      .clk   (clock50MHz),
      .rst_n (reset),
      .we    (wr_fire && bank_sel_q),
      .waddr (bus.wr_row),
      .wdata (bus.wr_data),
      .raddr (bus.rd_row),
      .rdata (rd0)
   );

   matrix_bank #(.ROWS(ROWS), .COLS(COLS)) u_bank1 (
      .clk   (clock50MHz),
      .rst_n (reset),
      .we    (wr_fire && !bank_sel_q),
      .waddr (bus.wr_row),
      .wdata (bus.wr_data),
      .raddr (bus.rd_row),
      .rdata (rd1)
   );

   always_comb begin
      state_d     = state_q;
      bank_sel_d  = bank_sel_q;
      frame_cnt_d = frame_cnt_q;
      swap_done_d = swap;
      // read uses the pre-edge select, so the swap cycle still shows the old front
      rd_data_d   = bank_sel_q ? rd1 : rd0;
      if (state_q == ST_FILL) begin
         if (bus.commit) state_d = ST_PENDING;
      end else if (swap) begin
         state_d     = ST_FILL;
         bank_sel_d  = ~bank_sel_q;
         frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
   end

   always_ff @(posedge clock50MHz or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_FILL;
         bank_sel_q  <= 1'b0;
         rd_data_q   <= '0;
         swap_done_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         bank_sel_q  <= bank_sel_d;
         rd_data_q   <= rd_data_d;
         swap_done_q <= swap_done_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end
endmodule
